clk_enable_gen: RTL and testbench

//   Multi-channel programmable clock-enable generator; successor to the fixed divide-by-5 VGA divider.

---
 rtl/clk_enable_gen.sv | 122 ++++++++++++
 tb/tb_clk_enable_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: per-channel tick strobe and pulse/square
// clk_out, with a run-time divisor that is double-buffered and only swapped at a period wrap.

module clk_enable_ch #(
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic             sync,
  input  logic             wr,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RESET_DIV);

  logic [CNT_W-1:0] cnt, d_act, d_shd;
  logic             pend;
  logic             wrap;

  assign wrap = (cnt == d_act);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      d_act   <= RST_D;
      d_shd   <= RST_D;
      pend    <= 1'b0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
    end else if (sync) begin
      // Phase restart: a same-cycle write bypasses the shadow and lands in d_act directly.
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      pend    <= 1'b0;
      if (wr) begin
        d_act <= div_val;
        d_shd <= div_val;
      end else if (pend) begin
        d_act <= d_shd;
      end
    end else if (!en) begin
      cnt     <= '0;
      tick    <= 1'b0;
      clk_out <= 1'b0;
      if (pend) begin
        d_act <= d_shd;
        pend  <= 1'b0;
      end
      if (wr) begin
        d_shd <= div_val;
        pend  <= 1'b1;
      end
    end else begin
      if (wrap) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= mode ? ~clk_out : 1'b1;
        if (pend) begin
          d_act <= d_shd;
          pend  <= 1'b0;
        end
      end else begin
        cnt     <= cnt + CNT_W'(1);
        tick    <= 1'b0;
        clk_out <= mode ? clk_out : 1'b0;
      end
      // A write landing on a wrap cycle stays pending for the following wrap.
      if (wr) begin
        d_shd <= div_val;
        pend  <= 1'b1;
      end
    end
  end

endmodule

module clk_enable_gen #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 16,
  parameter int RESET_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              sync,
  input  logic              div_wr,
  input  logic [2:0]        div_sel,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
);

  logic [NUM_CH-1:0] wr;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    // Out-of-range div_sel matches no channel, so such writes are dropped.
    assign wr[g] = div_wr && (div_sel == 3'(g));

    clk_enable_ch #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .en      (en[g]),
      .mode    (mode[g]),
      .sync    (sync),
      .wr      (wr[g]),
      .div_val (div_val),
      .tick    (tick[g]),
      .clk_out (clk_out[g])
    );
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen: table-driven steady-state vectors plus hand sequences
// for divisor updates, enable gating, sync, ignored writes and asynchronous reset.

module tb_clk_enable_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  en = '0, mode = '0;
  logic        sync = 1'b0, div_wr = 1'b0;
  logic [2:0]  div_sel = '0;
  logic [15:0] div_val = '0;
  logic [1:0]  tick, clk_out;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0] en;
    logic [1:0] mode;
    logic [1:0] tick;
    logic [1:0] clk_out;
  } vec_t;

  vec_t vec [0:29];

  clk_enable_gen #(.NUM_CH(2), .CNT_W(16), .RESET_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sync(sync), .div_wr(div_wr),
    .div_sel(div_sel), .div_val(div_val), .tick(tick), .clk_out(clk_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s c=%0d got=%b exp=%b", nm, c, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = '0; mode = '0; sync = 1'b0;
    div_wr = 1'b0; div_sel = '0; div_val = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_tick", 0, tick, 2'b00);
    chk("rst_clk", 0, clk_out, 2'b00);
    rst = 1'b0;
  endtask

  task automatic run_vec(input int lo, input int hi, input string nm);
    for (int i = lo; i <= hi; i++) begin
      en = vec[i].en; mode = vec[i].mode;
      cyc();
      chk({nm, "_tick"}, i - lo + 1, tick, vec[i].tick);
      chk({nm, "_clk"}, i - lo + 1, clk_out, vec[i].clk_out);
    end
  endtask

  initial begin
    logic [1:0] et, ec;

    // Legacy divide-by-5 pulse (0..9) and square/period-4 mix (10..29).
    for (int i = 0; i < 10; i++) begin
      et = ((i + 1) % 5 == 0) ? 2'b11 : 2'b00;
      vec[i] = '{2'b11, 2'b00, et, et};
    end
    for (int i = 0; i < 20; i++) begin
      int c;
      c = i + 1;
      et = {1'(c % 2 == 0), 1'(c % 5 == 0)};
      ec = {1'((c / 2) % 2 == 1), 1'((c / 5) % 2 == 1)};
      vec[10 + i] = '{2'b11, 2'b11, et, ec};
    end

    // 1: legacy ratio from reset
    do_reset();
    run_vec(0, 9, "legacy");

    // 2: ch1 divisor 1 loaded while disabled, then both square
    do_reset();
    div_wr = 1'b1; div_sel = 3'd1; div_val = 16'd1;
    cyc();
    div_wr = 1'b0;
    cyc();
    chk("dis_tick", 0, tick, 2'b00);
    run_vec(10, 29, "square");

    // 3: mid-period write to 9, then a write coinciding with a wrap
    do_reset();
    en = 2'b01;
    for (int c = 1; c <= 41; c++) begin
      div_wr  = (c == 3) || (c == 25);
      div_sel = 3'd0;
      div_val = (c == 25) ? 16'd2 : 16'd9;
      cyc();
      et = {1'b0, 1'(c == 5 || c == 15 || c == 25 || c == 35 || c == 38 || c == 41)};
      chk("redivide", c, tick, et);
      chk("redivide_clk", c, clk_out, et);
    end
    div_wr = 1'b0;

    // 4: divisor 0 -> continuous tick, square toggles every cycle
    do_reset();
    en = 2'b01; mode = 2'b01;
    for (int c = 1; c <= 12; c++) begin
      div_wr = (c == 1); div_sel = 3'd0; div_val = 16'd0;
      cyc();
      chk("div0_tick", c, tick, {1'b0, 1'(c >= 5)});
      chk("div0_clk", c, clk_out, {1'b0, 1'(c >= 5 && (c % 2 == 1))});
    end
    div_wr = 1'b0;

    // 5: ch1 gated for 3 cycles, sync restart with an out-of-range write
    do_reset();
    for (int c = 1; c <= 23; c++) begin
      en      = (c >= 3 && c <= 5) ? 2'b01 : 2'b11;
      sync    = (c == 13);
      div_wr  = (c == 13);
      div_sel = 3'd7;
      div_val = 16'd1;
      cyc();
      if (c <= 12)      et = {1'(c == 10), 1'(c == 5 || c == 10)};
      else if (c == 13) et = 2'b00;
      else              et = (c == 18 || c == 23) ? 2'b11 : 2'b00;
      chk("gate_sync_tick", c, tick, et);
      chk("gate_sync_clk", c, clk_out, et);
    end
    sync = 1'b0; div_wr = 1'b0;

    // 6: asynchronous reset mid-period restores divisor 4
    do_reset();
    div_wr = 1'b1; div_sel = 3'd0; div_val = 16'd2;
    cyc();
    div_wr = 1'b0;
    cyc();
    en = 2'b01; mode = 2'b01;
    for (int c = 3; c <= 5; c++) begin
      cyc();
      chk("pre_rst_tick", c, tick, {1'b0, 1'(c == 5)});
      chk("pre_rst_clk", c, clk_out, {1'b0, 1'(c == 5)});
    end
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tick", 0, tick, 2'b00);
    chk("async_rst_clk", 0, clk_out, 2'b00);
    @(negedge clk);
    rst = 1'b0; mode = 2'b00;
    for (int c = 1; c <= 5; c++) begin
      cyc();
      chk("post_rst_tick", c, tick, {1'b0, 1'(c == 5)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
